fft_bitrev_reorder: RTL and testbench

//  Output-side reorder buffer for the 32-point SDF FFT. Consumes the bit-reversed-order

---
 rtl/fft_bitrev_reorder.sv | 94 +++++++++
 tb/tb_fft_bitrev_reorder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning a bit-reversed FFT output stream into natural order
module fft_bitrev_reorder #(
    parameter int LOG2N = 5,
    parameter int W     = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [W-1:0]     data_in_r,
    input  logic [W-1:0]     data_in_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [W-1:0]     data_out_r,
    output logic [W-1:0]     data_out_i,
    output logic [LOG2N-1:0] index_o,
    output logic             first_o,
    output logic             last_o,
    output logic             overflow_o
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] KMAX = LOG2N'(N - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t           state, state_nx;
    logic [2*W-1:0]   mem [2][N];
    logic [LOG2N-1:0] wr_cnt, rd_cnt;
    logic             wr_bank, rd_bank;
    logic [1:0]       full, full_nx;
    logic             wr_en, wr_wrap, ld, rd_wrap;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // state always mirrors full[rd_bank]; it is registered from the next-cycle view
    always_comb begin
        wr_en    = valid_i && !full[wr_bank];
        wr_wrap  = wr_en && wr_cnt == KMAX;
        ld       = state == READ && (!valid_o || ready_i);
        rd_wrap  = ld && rd_cnt == KMAX;
        full_nx  = full;
        if (wr_wrap) full_nx[wr_bank] = 1'b1;
        if (rd_wrap) full_nx[rd_bank] = 1'b0;
        state_nx = full_nx[rd_bank ^ rd_wrap] ? READ : IDLE;
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_bank][bitrev(wr_cnt)] <= {data_in_r, data_in_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            full       <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
            index_o    <= '0;
            first_o    <= 1'b0;
            last_o     <= 1'b0;
        end else begin
            state <= state_nx;
            full  <= full_nx;
            if (wr_en) begin
                wr_cnt  <= wr_cnt + 1'b1;
                wr_bank <= wr_bank ^ wr_wrap;
            end
            if (valid_i && full[wr_bank]) overflow_o <= 1'b1;
            if (ld) begin
                {data_out_r, data_out_i} <= mem[rd_bank][rd_cnt];
                index_o <= rd_cnt;
                first_o <= rd_cnt == '0;
                last_o  <= rd_cnt == KMAX;
                valid_o <= 1'b1;
                rd_cnt  <= rd_cnt + 1'b1;
                rd_bank <= rd_bank ^ rd_wrap;
            end else if (!valid_o || ready_i) begin
                valid_o    <= 1'b0;
                data_out_r <= '0;
                data_out_i <= '0;
                index_o    <= '0;
                first_o    <= 1'b0;
                last_o     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: scoreboard bench with a frame-level reference model of the reorder buffer
module tb_fft_bitrev_reorder;
    logic        clk, rst_n, valid_i, ready_i;
    logic [16:0] data_in_r, data_in_i, data_out_r, data_out_i;
    logic        valid_o, first_o, last_o, overflow_o;
    logic [4:0]  index_o;

    fft_bitrev_reorder #(.LOG2N(5), .W(17)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_in_r(data_in_r),
        .data_in_i(data_in_i), .ready_i(ready_i), .valid_o(valid_o),
        .data_out_r(data_out_r), .data_out_i(data_out_i), .index_o(index_o),
        .first_o(first_o), .last_o(last_o), .overflow_o(overflow_o)
    );

    typedef struct {
        logic [16:0] re;
        logic [16:0] im;
        logic [4:0]  idx;
    } item_t;

    item_t       q[$];
    logic [16:0] part_r[32], part_i[32];
    int          pcnt, frames_done, frames_popped;
    int          compared, mismatched;
    bit          rmode, rfix;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        ready_i = 1;
        forever begin
            @(negedge clk);
            #1;
            ready_i = rmode ? ($urandom_range(0, 3) != 0) : rfix;
        end
    end

    function automatic logic [4:0] brev(input logic [4:0] k);
        logic [4:0] r;
        r = {<<{k}};
        return r;
    endfunction

    // a frame completes when 32 samples are accepted; output k is input sample brev(k)
    task automatic model_accept(input logic [16:0] re, input logic [16:0] im);
        part_r[pcnt] = re;
        part_i[pcnt] = im;
        pcnt++;
        if (pcnt == 32) begin
            for (int k = 0; k < 32; k++) q.push_back('{part_r[brev(5'(k))], part_i[brev(5'(k))], 5'(k)});
            pcnt = 0;
            frames_done++;
        end
    endtask

    task automatic send(input logic [16:0] re, input logic [16:0] im, input bit gate);
        int b = 0;
        @(negedge clk);
        #1;
        while (gate && frames_done - frames_popped >= 2 && b < 3000) begin
            valid_i = 0;
            b++;
            @(negedge clk);
            #1;
        end
        if (b >= 3000) begin
            compared++;
            mismatched++;
            $display("FAIL send_wait: buffer never freed (held=%0d)", frames_done - frames_popped);
        end
        valid_i   = 1;
        data_in_r = re;
        data_in_i = im;
        if (frames_done - frames_popped < 2) model_accept(re, im);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            valid_i = 0;
        end
    endtask

    task automatic check_zero(input string nm);
        compared++;
        if ({valid_o, data_out_r, data_out_i, index_o, first_o, last_o, overflow_o} != '0) begin
            mismatched++;
            $display("FAIL %s: outputs v=%b r=%h i=%h k=%0d f=%b l=%b ovf=%b, want all 0",
                     nm, valid_o, data_out_r, data_out_i, index_o, first_o, last_o, overflow_o);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        valid_i = 0;
        rst_n   = 0;
        #1;
        check_zero("reset_async");
        q.delete();
        pcnt = 0;
        frames_done = 0;
        frames_popped = 0;
        @(negedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic drain(input string nm);
        int b = 0;
        while (q.size() > 0 && b < 5000) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d outputs missing, want 0", nm, q.size());
        end
    endtask

    task automatic run_len(input int n, input string nm);
        int b = 0;
        int c = 0;
        while (!valid_o && b < 3000) begin
            @(negedge clk);
            b++;
        end
        while (valid_o && c < 1000) begin
            c++;
            @(negedge clk);
        end
        compared++;
        if (c != n) begin
            mismatched++;
            $display("FAIL %s_burst: contiguous valid run %0d, want %0d", nm, c, n);
        end
    endtask

    // monitor: a new item appears when valid_o is set and the previous one was taken or absent
    initial begin
        logic        pv;
        logic [16:0] pr, pi;
        logic [4:0]  pk;
        logic        pf, pl;
        item_t       e;
        pv = 0;
        forever begin
            @(negedge clk);
            if (valid_o && pv && !ready_i) begin
                compared++;
                if (data_out_r !== pr || data_out_i !== pi || index_o !== pk || first_o !== pf || last_o !== pl) begin
                    mismatched++;
                    $display("FAIL hold: k=%0d r=%h i=%h changed during stall, want k=%0d r=%h i=%h",
                             index_o, data_out_r, data_out_i, pk, pr, pi);
                end
            end else if (valid_o) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected: output k=%0d r=%h with nothing expected", index_o, data_out_r);
                end else begin
                    e = q.pop_front();
                    if (data_out_r !== e.re || data_out_i !== e.im || index_o !== e.idx ||
                        first_o !== (e.idx == 0) || last_o !== (e.idx == 31)) begin
                        mismatched++;
                        $display("FAIL item: got k=%0d r=%h i=%h f=%b l=%b, want k=%0d r=%h i=%h f=%b l=%b",
                                 index_o, data_out_r, data_out_i, first_o, last_o,
                                 e.idx, e.re, e.im, e.idx == 0, e.idx == 31);
                    end
                    if (e.idx == 31) frames_popped++;
                end
            end
            pv = valid_o;
            pr = data_out_r;
            pi = data_out_i;
            pk = index_o;
            pf = first_o;
            pl = last_o;
        end
    end

    initial begin
        compared = 0;
        mismatched = 0;
        rmode = 0;
        rfix = 1;
        rst_n = 0;
        valid_i = 0;
        data_in_r = 0;
        data_in_i = 0;
        pcnt = 0;
        frames_done = 0;
        frames_popped = 0;
        repeat (2) @(negedge clk);
        check_zero("reset_init");
        #1;
        rst_n = 1;

        // 1: single ramp frame, latency and first/last flags
        do_reset();
        for (int j = 0; j < 32; j++) send(17'(j), 17'(-j), 1);
        @(negedge clk);
        #1;
        valid_i = 0;
        compared++;
        if (valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL lat_early: valid_o=%b one edge after last write, want 0", valid_o);
        end
        @(negedge clk);
        compared++;
        if (valid_o !== 1'b1 || index_o !== 5'd0 || first_o !== 1'b1 || data_out_r !== 17'd0) begin
            mismatched++;
            $display("FAIL lat_x0: v=%b k=%0d f=%b r=%h, want v=1 k=0 f=1 r=0", valid_o, index_o, first_o, data_out_r);
        end
        @(negedge clk);
        compared++;
        if (index_o !== 5'd1 || data_out_r !== 17'd16 || data_out_i !== 17'(-16)) begin
            mismatched++;
            $display("FAIL lat_x1: k=%0d r=%h i=%h, want k=1 r=10 i=%h", index_o, data_out_r, data_out_i, 17'(-16));
        end
        drain("t1");
        compared++;
        if (overflow_o !== 1'b0) begin
            mismatched++;
            $display("FAIL t1_ovf: overflow_o=%b, want 0", overflow_o);
        end

        // 2: four back-to-back random frames stream with no bubble
        do_reset();
        fork
            begin
                for (int j = 0; j < 128; j++) send(17'($urandom), 17'($urandom), 1);
                idle(1);
            end
            run_len(128, "t2");
        join
        drain("t2");

        // 3: sparse input still gives one contiguous output burst
        do_reset();
        fork
            begin
                for (int j = 0; j < 32; j++) begin
                    send(17'($urandom), 17'($urandom), 1);
                    idle(1);
                end
            end
            run_len(32, "t3");
        join
        drain("t3");

        // 4: stalled output, third frame dropped entirely
        do_reset();
        rfix = 0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 96; j++) send(17'(j * 3 + 1), 17'(j * 7), 0);
        idle(2);
        compared++;
        if (overflow_o !== 1'b1 || q.size() != 63) begin
            mismatched++;
            $display("FAIL t4_ovf: overflow_o=%b pending=%0d, want 1 and 63", overflow_o, q.size());
        end
        rfix = 1;
        drain("t4");
        compared++;
        if (overflow_o !== 1'b1) begin
            mismatched++;
            $display("FAIL t4_sticky: overflow_o=%b, want 1", overflow_o);
        end

        // 5: random ready and random input gaps
        do_reset();
        rmode = 1;
        for (int j = 0; j < 128; j++) begin
            send(17'($urandom), 17'($urandom), 1);
            idle($urandom_range(0, 2));
        end
        rmode = 0;
        rfix = 1;
        drain("t5");
        compared++;
        if (overflow_o !== 1'b0) begin
            mismatched++;
            $display("FAIL t5_ovf: overflow_o=%b, want 0", overflow_o);
        end

        // 6: reset during a partial frame and during output
        do_reset();
        for (int j = 0; j < 10; j++) send(17'(1000 + j), 17'(2000 + j), 1);
        do_reset();
        for (int j = 0; j < 32; j++) send(17'($urandom), 17'($urandom), 1);
        idle(6);
        do_reset();
        for (int j = 0; j < 32; j++) send(17'(j * 5), 17'(-j * 9), 1);
        idle(1);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
